// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, widths and opcode legality shared by the ALU command queue
package alu_pkg;

  localparam int OP_W       = 3;
  localparam int DEF_DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT = 3'b110;

  // 000 and 111 still flow through the queue; the ALU just returns 0 for them
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op != '0) && (op != '1);
  endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// rtl/alu_cmd_queue_if.sv - command, ALU and result signals of the ALU command queue
interface alu_cmd_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DEF_DATA_W
) ();
  import alu_pkg::*;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [OP_W-1:0]              cmd_op;
  logic [DATA_W-1:0]            cmd_a;
  logic [DATA_W-1:0]            cmd_b;

  logic [OP_W-1:0]              alu_op;
  logic [DATA_W-1:0]            alu_a;
  logic [DATA_W-1:0]            alu_b;
  logic [DATA_W-1:0]            alu_r;

  logic                         res_valid;
  logic                         res_ready;
  logic [DATA_W-1:0]            res_data;
  logic                         res_zero;
  logic [OP_W-1:0]              res_op;
  logic                         res_illegal;

  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_r, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b,
    input  res_valid, res_data, res_zero, res_op, res_illegal, count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_r, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b,
    output res_valid, res_data, res_zero, res_op, res_illegal, count
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; storage itself is not reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - queued command front-end for the ALU with an in-order registered result
module alu_cmd_queue import alu_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  alu_cmd_queue_if.slave  bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = OP_W + 2*DATA_W;

  logic [EW-1:0] head;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign push = bus.cmd_valid && bus.cmd_ready && !full;
  assign pop  = !empty && (!bus.res_valid || bus.res_ready);

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.count  = count;
  assign bus.alu_op = empty ? '0 : head[EW-1 -: OP_W];
  assign bus.alu_a  = empty ? '0 : head[2*DATA_W-1 -: DATA_W];
  assign bus.alu_b  = empty ? '0 : head[DATA_W-1:0];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  // Registered from next-state occupancy so res_ready never reaches cmd_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) bus.cmd_ready <= 1'b0;
    else     bus.cmd_ready <= (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_zero    <= 1'b0;
      bus.res_op      <= '0;
      bus.res_illegal <= 1'b0;
    end else if (pop) begin
      bus.res_valid   <= 1'b1;
      bus.res_data    <= bus.alu_r;
      bus.res_zero    <= (bus.alu_r == '0);
      bus.res_op      <= bus.alu_op;
      bus.res_illegal <= !is_legal_op(bus.alu_op);
    end else if (bus.res_ready) begin
      bus.res_valid   <= 1'b0;
    end
  end

endmodule
